// File: rtl/sparse_hv_gen_128bit.sv
// sparse_hv_gen_128bit
//   Builds a 128-bit hypervector with exactly K ones at pseudo-random positions.
//   A 16-bit Galois LFSR (mask 16'hB400, shifting right) proposes one candidate
//   bit index per cycle from its low 7 bits. A candidate that is already set is
//   a collision and is skipped.
//   Optional feature macro: SPARSE_HV_SEED_LOAD_EN adds the seed_we/seed_in ports,
//   which let the LFSR be reloaded while the block is idle.
//
//   Handshake: a start is accepted on a rising edge where ready=1. out_valid
//   stays high with hv_out stable until the rising edge where out_ready=1.
//   start is ignored while ready=0.
module sparse_hv_gen_128bit #(
  parameter int                WIDTH  = 128,
  parameter int                CNT_W  = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  density,
  output logic              ready,
  output logic [WIDTH-1:0]  hv_out,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef SPARSE_HV_SEED_LOAD_EN
  input  logic              seed_we,
  input  logic [LFSR_W-1:0] seed_in,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int                IDX_W = $clog2(WIDTH);
  localparam logic [LFSR_W-1:0] TAPS  = 16'hB400;
  localparam logic [CNT_W-1:0]  K_MAX = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   hv_q, hv_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]   idx;
  logic [LFSR_W-1:0]  lfsr_step;
  logic [CNT_W-1:0]   count_inc;

  // One Galois step of the LFSR and the candidate index it currently offers
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    idx       = lfsr_q[IDX_W-1:0];
    count_inc = count_q + CNT_W'(1);
  end

  // Next-state logic: accept in IDLE, place one candidate per GEN cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    hv_d    = hv_q;
    count_d = count_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
`ifdef SPARSE_HV_SEED_LOAD_EN
        // A zero seed would lock the LFSR, so it falls back to SEED
        if (seed_we) lfsr_d = (seed_in == '0) ? SEED : seed_in;
`endif
        if (start) begin
          k_d     = (density >= K_MAX) ? K_MAX : density;
          hv_d    = '0;
          count_d = '0;
          if (density == '0) begin
            state_d = DONE;
          end else if (density >= K_MAX) begin
            hv_d    = '1;
            state_d = DONE;
          end else begin
            state_d = GEN;
          end
        end
      end
      GEN: begin
        lfsr_d = lfsr_step;
        if (!hv_q[idx]) begin
          hv_d[idx] = 1'b1;
          count_d   = count_inc;
          if (count_inc == k_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset mid-run drops the partial vector
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      hv_q    <= '0;
      count_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      hv_q    <= hv_d;
      count_q <= count_d;
      k_q     <= k_d;
    end
  end

  // Outputs decode directly from state
  always_comb begin
    ready       = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    hv_out      = hv_q;
    dbg_state_o = state_q;
  end

endmodule
